// File: rtl/gpr_wb_if.sv
// gpr_wb_if: ID hazard query, long-latency result offer, pipeline writeback and RF write port bundle.
interface gpr_wb_if;
    logic        id_valid;
    logic        id_go;
    logic [4:0]  id_r1;
    logic [4:0]  id_r2;
    logic        id_r1_used;
    logic        id_r2_used;
    logic [4:0]  id_rw;
    logic        id_long;
    logic        issue_stall;
    logic        lu_valid;
    logic [4:0]  lu_rw;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        wb_we;
    logic [4:0]  wb_rw;
    logic [31:0] wb_din;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    modport master (
        output id_valid, id_go, id_r1, id_r2, id_r1_used, id_r2_used, id_rw, id_long,
        output lu_valid, lu_rw, lu_data, wb_we, wb_rw, wb_din,
        input  issue_stall, lu_ready, rf_we, rf_waddr, rf_wdata
    );
    modport slave (
        input  id_valid, id_go, id_r1, id_r2, id_r1_used, id_r2_used, id_rw, id_long,
        input  lu_valid, lu_rw, lu_data, wb_we, wb_rw, wb_din,
        output issue_stall, lu_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/gpr_wb_scoreboard.sv
// gpr_wb_scoreboard: arbitrates the GPR write port between pipeline writeback and buffered
// long-latency results, and stalls ID on hazards against outstanding long-latency destinations.
module gpr_wb_scoreboard #(
    parameter int PEND_DEPTH = 2,
    parameter int MAX_OUT    = 4
) (
    input logic     clk,
    input logic     resetn,
    gpr_wb_if.slave bus
);
    localparam int PW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
    localparam int CW = $clog2(PEND_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [4:0]    fifo_rw_q   [PEND_DEPTH];
    logic [31:0]   fifo_data_q [PEND_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [31:0]   sb_q, sb_d;
    logic [OW-1:0] out_cnt_q, out_cnt_d;
    logic          push, pop, sb_set, sb_clr;
    logic [4:0]    head_rw;
    logic [31:0]   head_data;

    assign head_rw   = fifo_rw_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];
    assign push      = bus.lu_valid & bus.lu_ready;
    assign pop       = !bus.wb_we && fifo_cnt_q != '0;
    assign sb_set    = bus.id_go & bus.id_long & (bus.id_rw != 5'd0);
    assign sb_clr    = pop & (head_rw != 5'd0);

    always_comb begin
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        out_cnt_d  = out_cnt_q + OW'(sb_set) - OW'(sb_clr);
        sb_d       = sb_q;
        if (sb_clr) sb_d[head_rw] = 1'b0;
        if (sb_set) sb_d[bus.id_rw] = 1'b1;
        sb_d[0]    = 1'b0;
    end

    // Any nonzero id_rw is a destination: long ops and wb-path writes alike hit WAW.
    assign bus.issue_stall = bus.id_valid & (
        (bus.id_r1_used & sb_q[bus.id_r1]) |
        (bus.id_r2_used & sb_q[bus.id_r2]) |
        ((bus.id_rw != 5'd0) & sb_q[bus.id_rw]) |
        (bus.id_long & (out_cnt_q == OW'(MAX_OUT))));
    assign bus.lu_ready = fifo_cnt_q != CW'(PEND_DEPTH);
    assign bus.rf_we    = resetn & (bus.wb_we ? (bus.wb_rw != 5'd0) : sb_clr);
    assign bus.rf_waddr = !resetn ? 5'd0 : bus.wb_we ? bus.wb_rw : pop ? head_rw : 5'd0;
    assign bus.rf_wdata = !resetn ? 32'd0 : bus.wb_we ? bus.wb_din : pop ? head_data : 32'd0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            sb_q       <= '0;
            out_cnt_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_q + PW'(pop);
            wr_ptr_q   <= wr_ptr_q + PW'(push);
            fifo_cnt_q <= fifo_cnt_d;
            sb_q       <= sb_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rw_q[wr_ptr_q]   <= bus.lu_rw;
            fifo_data_q[wr_ptr_q] <= bus.lu_data;
        end
    end

    sb_same_bit: assert property (@(posedge clk) disable iff (!resetn)
        !(sb_set && sb_clr && bus.id_rw == head_rw));
endmodule

// File: tb/tb_gpr_wb_scoreboard.sv
// tb_gpr_wb_scoreboard: directed vectors; expected RF writes are queued by stimulus and
// popped by a monitor on every rf_we, while stall/ready levels are checked inline.
module tb_gpr_wb_scoreboard;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    gpr_wb_if bus();
    gpr_wb_scoreboard dut (.clk(clk), .resetn(resetn), .bus(bus));

    int checks = 0;
    int failures = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && bus.rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rf_write unexpected actual=%0d:%h expected=none", bus.rf_waddr, bus.rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.rf_waddr, bus.rf_wdata} !== mon_e) begin
                    failures++;
                    $display("FAIL rf_write actual=%0d:%h expected=%0d:%h",
                             bus.rf_waddr, bus.rf_wdata, mon_e[36:32], mon_e[31:0]);
                end
            end
        end
    end

    task automatic idle();
        bus.id_valid = 0; bus.id_go = 0; bus.id_r1 = 0; bus.id_r2 = 0;
        bus.id_r1_used = 0; bus.id_r2_used = 0; bus.id_rw = 0; bus.id_long = 0;
        bus.lu_valid = 0; bus.lu_rw = 0; bus.lu_data = 0;
        bus.wb_we = 0; bus.wb_rw = 0; bus.wb_din = 0;
    endtask
    task automatic cyc();
        @(posedge clk); #1;
    endtask
    task automatic samp();
        @(negedge clk);
    endtask
    task automatic expw(input logic [4:0] rw, input logic [31:0] d);
        exp_q.push_back({rw, d});
    endtask
    task automatic wb(input logic [4:0] rw, input logic [31:0] d);
        bus.wb_we = 1; bus.wb_rw = rw; bus.wb_din = d;
        if (rw != 0) expw(rw, d);
    endtask
    task automatic lu(input logic [4:0] rw, input logic [31:0] d);
        bus.lu_valid = 1; bus.lu_rw = rw; bus.lu_data = d;
    endtask
    task automatic issue_long(input logic [4:0] rw);
        bus.id_valid = 1; bus.id_go = 1; bus.id_long = 1; bus.id_rw = rw;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        samp();
        chk("rst_stall", bus.issue_stall, 0);
        chk("rst_lu_ready", bus.lu_ready, 1);
        chk("rst_rf_we", bus.rf_we, 0);
        chk("rst_rf_waddr", bus.rf_waddr, 0);
        chk("rst_rf_wdata", bus.rf_wdata, 0);
        resetn = 1;
        cyc();
        // RAW on r5 until the cycle after its RF write
        idle(); issue_long(5); samp(); chk("t1_issue", bus.issue_stall, 0); cyc();
        idle(); bus.id_valid = 1; bus.id_r1 = 5; bus.id_r1_used = 1;
        samp(); chk("t1_raw", bus.issue_stall, 1); cyc();
        lu(5, 32'h555); samp(); chk("t1_raw_offer", bus.issue_stall, 1); cyc();
        bus.lu_valid = 0; expw(5, 32'h555);
        samp(); chk("t1_raw_at_write", bus.issue_stall, 1); cyc();
        samp(); chk("t1_released", bus.issue_stall, 0); cyc();
        // long result waits behind three pipeline writes
        idle(); issue_long(7); lu(7, 32'hDEADBEEF); wb(10, 32'hA0); samp(); cyc();
        idle(); wb(11, 32'hA1); samp(); cyc();
        idle(); wb(12, 32'hA2); samp(); cyc();
        idle(); expw(7, 32'hDEADBEEF); samp(); chk("t2_lu_we", bus.rf_we, 1); cyc();
        idle(); samp(); chk("t2_idle_we", bus.rf_we, 0); cyc();
        // fill FIFO under wb, ready returns only the cycle after a pop
        idle(); issue_long(20); lu(20, 32'hC0); wb(13, 32'hB0); samp(); cyc();
        idle(); issue_long(21); lu(21, 32'hC1); wb(14, 32'hB1);
        samp(); chk("t3_ready_one", bus.lu_ready, 1); cyc();
        idle(); wb(15, 32'hB2); samp(); chk("t3_full", bus.lu_ready, 0); cyc();
        idle(); expw(20, 32'hC0); samp(); chk("t3_no_bypass", bus.lu_ready, 0); cyc();
        idle(); expw(21, 32'hC1); samp(); chk("t3_ready_again", bus.lu_ready, 1); cyc();
        idle(); samp(); cyc();
        // outstanding limit
        for (int i = 1; i <= 4; i++) begin
            idle(); issue_long(5'(i)); samp(); chk("t4_issue", bus.issue_stall, 0); cyc();
        end
        idle(); bus.id_valid = 1; bus.id_long = 1; bus.id_rw = 6; lu(1, 32'hD1);
        samp(); chk("t4_max_out", bus.issue_stall, 1); cyc();
        bus.lu_valid = 0; expw(1, 32'hD1); samp(); chk("t4_at_write", bus.issue_stall, 1); cyc();
        samp(); chk("t4_released", bus.issue_stall, 0); cyc();
        idle(); lu(2, 32'hD2); samp(); cyc();
        idle(); lu(3, 32'hD3); expw(2, 32'hD2); samp(); cyc();
        idle(); lu(4, 32'hD4); expw(3, 32'hD3); samp(); cyc();
        idle(); expw(4, 32'hD4); samp(); cyc();
        // WAW and used-qualified RAW on r9
        idle(); issue_long(9); samp(); cyc();
        idle(); bus.id_valid = 1; bus.id_rw = 9; bus.id_r1 = 9;
        samp(); chk("t5_waw", bus.issue_stall, 1); cyc();
        bus.id_rw = 3; bus.id_r2 = 9; samp(); chk("t5_unused", bus.issue_stall, 0); cyc();
        bus.id_r2_used = 1; samp(); chk("t5_raw_r2", bus.issue_stall, 1); cyc();
        bus.id_valid = 0; samp(); chk("t5_invalid", bus.issue_stall, 0); cyc();
        idle(); lu(9, 32'h99); samp(); cyc();
        idle(); expw(9, 32'h99); samp(); cyc();
        // r0 writes suppressed, r0 entry still pops
        idle(); issue_long(0); wb(0, 32'h1234); samp(); chk("r0_wb_we", bus.rf_we, 0); cyc();
        idle(); lu(0, 32'h77); samp(); cyc();
        idle(); samp(); chk("r0_pop_we", bus.rf_we, 0); cyc();
        // reset with two buffered results and three pending bits
        idle(); issue_long(17); lu(17, 32'hE0); wb(22, 32'hF0); samp(); cyc();
        idle(); issue_long(18); lu(18, 32'hE1); wb(23, 32'hF1); samp(); cyc();
        idle(); issue_long(19); wb(24, 32'hF2); samp(); chk("t6_full", bus.lu_ready, 0); cyc();
        idle(); wb(25, 32'hF3); bus.id_valid = 1; bus.id_r1 = 17; bus.id_r1_used = 1;
        samp(); chk("t6_pre_stall", bus.issue_stall, 1); cyc();
        idle(); resetn = 0; bus.id_valid = 1; bus.id_r1 = 17; bus.id_r1_used = 1;
        samp();
        chk("t6_rst_we", bus.rf_we, 0);
        chk("t6_rst_ready", bus.lu_ready, 1);
        chk("t6_rst_stall", bus.issue_stall, 0);
        cyc();
        resetn = 1;
        samp();
        chk("t6_post_stall", bus.issue_stall, 0);
        chk("t6_post_we", bus.rf_we, 0);
        chk("t6_post_ready", bus.lu_ready, 1);
        cyc();
        idle(); repeat (3) begin samp(); cyc(); end
        chk("exp_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
